// File: rtl/uart_word_pkg.sv
// Shared constants and FSM state encoding for the UART word assembler.
package uart_word_pkg;

  localparam int unsigned NB_DATA_DEF    = 8;
  localparam int unsigned NB_WORD_DEF    = 32;
  localparam int unsigned NB_TIMEOUT_DEF = 16;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_OUTPUT  = 1'b1
  } state_t;

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte idle counter: counts enabled cycles, expires when the count equals a nonzero compare value.
module uart_byte_timer #(
  parameter int unsigned NB_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic [NB_TIMEOUT-1:0] i_cmp,
  output logic                  o_expire
);

  logic [NB_TIMEOUT-1:0] cnt;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= cnt + NB_TIMEOUT'(1);
    end
  end

  assign o_expire = (i_cmp != '0) && (cnt == i_cmp);

endmodule

// File: rtl/uart_word_assembler.sv
// Packs little-endian RX FIFO bytes into NB_WORD words with a valid/ready output.
// Define UART_WORD_TIMEOUT_EN to drop partial words after i_timeout_cmp idle cycles.
module uart_word_assembler
  import uart_word_pkg::*;
#(
  parameter int unsigned NB_DATA    = NB_DATA_DEF,
  parameter int unsigned NB_WORD    = NB_WORD_DEF,
  parameter int unsigned NB_TIMEOUT = NB_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [NB_DATA-1:0]    i_rdata,
  input  logic                  i_rx_empty,
  output logic                  o_rd,
  output logic [NB_WORD-1:0]    o_word,
  output logic                  o_word_valid,
  input  logic                  i_word_ready,
  input  logic                  i_flush,
  input  logic [NB_TIMEOUT-1:0] i_timeout_cmp,
  output logic                  o_timeout
);

  localparam int unsigned NB_BYTES = NB_WORD / NB_DATA;
  localparam int unsigned NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [NB_CNT-1:0] LAST_SLOT = NB_CNT'(NB_BYTES - 1);

  state_t            state;
  logic [NB_CNT-1:0] byte_cnt;
  logic              pop;
  logic              timeout_hit;

  assign pop  = (state == ST_COLLECT) && !i_rx_empty && !i_flush && !i_rst;
  assign o_rd = pop;

`ifdef UART_WORD_TIMEOUT_EN
  logic expire;

  uart_byte_timer #(
    .NB_TIMEOUT(NB_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .i_rst    (i_rst),
    .i_en     ((state == ST_COLLECT) && (byte_cnt != '0) && !pop),
    .i_clr    (pop || i_flush || timeout_hit),
    .i_cmp    (i_timeout_cmp),
    .o_expire (expire)
  );

  // A pop or flush in the expiry cycle takes precedence over the drop.
  assign timeout_hit = expire && (state == ST_COLLECT) && (byte_cnt != '0)
                       && !pop && !i_flush;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= timeout_hit;
    end
  end
`else
  logic unused_timeout_cmp;

  assign unused_timeout_cmp = ^i_timeout_cmp;
  assign timeout_hit        = 1'b0;
  assign o_timeout          = 1'b0;
`endif

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_COLLECT;
      byte_cnt     <= '0;
      o_word       <= '0;
      o_word_valid <= 1'b0;
    end else if (i_flush) begin
      state        <= ST_COLLECT;
      byte_cnt     <= '0;
      o_word_valid <= 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (pop) begin
            for (int unsigned i = 0; i < NB_BYTES; i++) begin
              if (byte_cnt == NB_CNT'(i)) begin
                o_word[i*NB_DATA +: NB_DATA] <= i_rdata;
              end
            end
            if (byte_cnt == LAST_SLOT) begin
              byte_cnt     <= '0;
              state        <= ST_OUTPUT;
              o_word_valid <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + NB_CNT'(1);
            end
          end else if (timeout_hit) begin
            byte_cnt <= '0;
          end
        end
        ST_OUTPUT: begin
          if (i_word_ready) begin
            state        <= ST_COLLECT;
            o_word_valid <= 1'b0;
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_assembler.sv
// Self-checking bench: FIFO environment, per-cycle reference model, directed and random scenarios.
`timescale 1ns/1ps
module tb_uart_word_assembler;

  localparam int unsigned NB_DATA    = 8;
  localparam int unsigned NB_WORD    = 32;
  localparam int unsigned NB_TIMEOUT = 16;
  localparam int unsigned NB_BYTES   = NB_WORD / NB_DATA;

  logic                  clk = 1'b0;
  logic                  i_rst;
  logic [NB_DATA-1:0]    i_rdata;
  logic                  i_rx_empty;
  logic                  o_rd;
  logic [NB_WORD-1:0]    o_word;
  logic                  o_word_valid;
  logic                  i_word_ready;
  logic                  i_flush;
  logic [NB_TIMEOUT-1:0] i_timeout_cmp;
  logic                  o_timeout;

  always #5 clk = ~clk;

  uart_word_assembler #(
    .NB_DATA   (NB_DATA),
    .NB_WORD   (NB_WORD),
    .NB_TIMEOUT(NB_TIMEOUT)
  ) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_rdata      (i_rdata),
    .i_rx_empty   (i_rx_empty),
    .o_rd         (o_rd),
    .o_word       (o_word),
    .o_word_valid (o_word_valid),
    .i_word_ready (i_word_ready),
    .i_flush      (i_flush),
    .i_timeout_cmp(i_timeout_cmp),
    .o_timeout    (o_timeout)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] fifo[$];
  logic       rd_seen = 1'b0;

  // Reference model: bytes gathered so far, pending word, idle cycles since last byte.
  logic [7:0]  m_bytes[$];
  bit          m_pending = 0;
  logic [31:0] m_word    = '0;
  int          m_idle    = 0;
  bit          m_to      = 0;

  int          rd_cnt, valid_cyc, to_cnt, cyc;
  int          first_rd_cyc, last_rd_cyc, first_valid_cyc;
  bit          prev_valid = 0;
  logic [31:0] got_words[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void refresh();
    i_rx_empty = (fifo.size() == 0);
    i_rdata    = (fifo.size() > 0) ? fifo[0] : '0;
  endfunction

  function automatic void push(logic [7:0] b);
    fifo.push_back(b);
    refresh();
  endfunction

  function automatic logic [31:0] word_at(int i);
    return (i < got_words.size()) ? got_words[i] : 'x;
  endfunction

  function automatic void clear_mon();
    rd_cnt = 0; valid_cyc = 0; to_cnt = 0;
    first_rd_cyc = 0; last_rd_cyc = 0; first_valid_cyc = 0;
    got_words.delete();
  endfunction

  // FIFO environment: pop the head byte the DUT strobed at this edge.
  always @(posedge clk) begin
    #1;
    if (rd_seen && fifo.size() > 0) void'(fifo.pop_front());
    refresh();
  end

  always @(negedge clk) begin
    bit exp_rd;
    if (i_rst) begin
      check("rst_rd", o_rd, 0);
      check("rst_valid", o_word_valid, 0);
      check("rst_word", o_word, 0);
      check("rst_timeout", o_timeout, 0);
      m_bytes.delete(); m_pending = 0; m_idle = 0; m_to = 0; prev_valid = 0;
    end else begin
      exp_rd = !m_pending && !i_rx_empty && !i_flush;
      check("rd", o_rd, exp_rd);
      check("word_valid", o_word_valid, m_pending);
      if (m_pending) check("word", o_word, m_word);
      check("timeout", o_timeout, m_to);

      if (o_rd) begin
        if (rd_cnt == 0) first_rd_cyc = cyc;
        rd_cnt++;
        last_rd_cyc = cyc;
      end
      if (o_word_valid) begin
        valid_cyc++;
        if (!prev_valid) begin
          got_words.push_back(o_word);
          first_valid_cyc = cyc;
        end
      end
      if (o_timeout) to_cnt++;
      prev_valid = o_word_valid;

      m_to = 0;
      if (i_flush) begin
        m_bytes.delete(); m_pending = 0; m_idle = 0;
      end else if (m_pending) begin
        if (i_word_ready) m_pending = 0;
      end else if (exp_rd) begin
        m_bytes.push_back(i_rdata);
        m_idle = 0;
        if (m_bytes.size() == NB_BYTES) begin
          m_word    = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          m_pending = 1;
          m_bytes.delete();
        end
      end
`ifdef UART_WORD_TIMEOUT_EN
      else if (m_bytes.size() > 0) begin
        if (i_timeout_cmp != 0 && m_idle == int'(i_timeout_cmp)) begin
          m_bytes.delete(); m_idle = 0; m_to = 1;
        end else begin
          m_idle++;
        end
      end
`endif
    end
    rd_seen = o_rd;
    cyc++;
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic settle();
    i_flush = 1'b1;
    fifo.delete();
    refresh();
    tick(1);
    i_flush      = 1'b0;
    i_word_ready = 1'b1;
    tick(2);
    clear_mon();
  endtask

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_word_ready = 1'b1; i_timeout_cmp = '0;
    clear_mon();
    refresh();
    tick(3);
    check("init_word", o_word, 0);
    check("init_valid", o_word_valid, 0);
    i_rst = 1'b0;
    tick(2);

    // Four bytes, consumer always ready.
    clear_mon();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    tick(8);
    check("s1_words", got_words.size(), 1);
    check("s1_word", word_at(0), 32'h44332211);
    check("s1_rd_cnt", rd_cnt, 4);
    check("s1_rd_span", last_rd_cyc - first_rd_cyc, 3);
    check("s1_latency", first_valid_cyc - last_rd_cyc, 1);
    check("s1_valid_cycles", valid_cyc, 1);

    // Backpressure: eight bytes queued, consumer stalled.
    settle();
    i_word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    tick(20);
    check("s2_rd_cnt", rd_cnt, 4);
    check("s2_valid_held", o_word_valid, 1);
    check("s2_word_held", o_word, 32'h04030201);
    check("s2_fifo_left", fifo.size(), 4);
    i_word_ready = 1'b1;
    tick(10);
    check("s2_words", got_words.size(), 2);
    check("s2_word2", word_at(1), 32'h08070605);

    // Flush discards a partial word.
    settle();
    push(8'hAA); push(8'hBB);
    tick(4);
    i_flush = 1'b1;
    tick(1);
    i_flush = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(i));
    tick(8);
    check("s3_words", got_words.size(), 1);
    check("s3_word", word_at(0), 32'h04030201);

    // Inter-byte timeout.
    i_timeout_cmp = 16'd10;
    settle();
    push(8'h55);
    tick(14);
`ifdef UART_WORD_TIMEOUT_EN
    check("s4_timeouts", to_cnt, 1);
    for (int i = 1; i <= 4; i++) push(8'(i));
    tick(8);
    check("s4_word", word_at(0), 32'h04030201);
`else
    check("s4_timeouts", to_cnt, 0);
    for (int i = 1; i <= 4; i++) push(8'(i));
    tick(8);
    check("s4_word", word_at(0), 32'h03020155);
`endif
    i_timeout_cmp = '0;
    settle();

    // Asynchronous reset mid-word.
    push(8'h01); push(8'h02); push(8'h03);
    tick(5);
    push(8'h77);
    i_rst = 1'b1;
    #1;
    check("s5_async_word", o_word, 0);
    check("s5_async_rd", o_rd, 0);
    tick(3);
    fifo.delete();
    refresh();
    i_rst = 1'b0;
    tick(1);
    clear_mon();
    for (int i = 1; i <= 4; i++) push(8'(i));
    tick(8);
    check("s5_words", got_words.size(), 1);
    check("s5_word", word_at(0), 32'h04030201);

    // Flush and handshake in the same cycle with bytes queued.
    settle();
    i_word_ready = 1'b0;
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    for (int i = 1; i <= 4; i++) push(8'(i));
    tick(8);
    check("s6_pending", o_word_valid, 1);
    i_flush = 1'b1; i_word_ready = 1'b1;
    tick(1);
    check("s6_valid_after_flush", o_word_valid, 0);
    i_flush = 1'b0;
    tick(8);
    check("s6_words", got_words.size(), 2);
    check("s6_word", word_at(1), 32'h04030201);

    // Randomized traffic against the model.
    for (int seg = 0; seg < 3; seg++) begin
      i_timeout_cmp = (seg == 0) ? 16'd0 : (seg == 1) ? 16'd4 : 16'd7;
      settle();
      repeat (600) begin
        if ($urandom_range(4) < 2 && fifo.size() < 16) push(8'($urandom));
        i_word_ready = ($urandom_range(2) != 0);
        i_flush      = ($urandom_range(63) == 0);
        tick(1);
      end
      i_flush = 1'b0;
    end
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_word_assembler.md
UART_WORD_ASSEMBLER -- requirements
Module: uart_word_assembler

Interface
REQ-001 Parameter NB_DATA, default 8: byte width delivered by the UART RX FIFO.
REQ-002 Parameter NB_WORD, default 32: assembled word width; SHALL be an integer multiple of NB_DATA, at least 2x.
REQ-003 Parameter NB_TIMEOUT, default 16: width of the inter-byte timeout counter and compare value.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 i_rdata  input  NB_DATA  RX FIFO head data, valid whenever i_rx_empty=0.
REQ-007 i_rx_empty  input  1  RX FIFO empty flag.
REQ-008 o_rd  output  1  RX FIFO pop strobe; one byte consumed per cycle asserted.
REQ-009 o_word  output  NB_WORD  assembled word.
REQ-010 o_word_valid  output  1  o_word holds a complete word.
REQ-011 i_word_ready  input  1  consumer accepts o_word when o_word_valid=1.
REQ-012 i_flush  input  1  synchronous discard of partial and pending word.
REQ-013 i_timeout_cmp  input  NB_TIMEOUT  idle-cycle limit between bytes; 0 disables timeout.
REQ-014 o_timeout  output  1  one-cycle pulse when a partial word is dropped by timeout.

Function
REQ-015 FSM states: ST_COLLECT (gathering bytes) and ST_OUTPUT (word held for consumer).
REQ-016 In ST_COLLECT, o_rd SHALL be combinationally 1 iff i_rx_empty=0 and i_flush=0; o_rd SHALL be 0 in ST_OUTPUT.
REQ-017 Each pop SHALL store i_rdata at byte slot byte_cnt; first byte of a word in o_word[NB_DATA-1:0] (little-endian).
REQ-018 byte_cnt SHALL increment per pop; pop of slot NB_WORD/NB_DATA-1 SHALL wrap byte_cnt to 0 and move to ST_OUTPUT.
REQ-019 o_word_valid SHALL assert the cycle after the final byte pop (latency 1) and stay 1 until handshake.
REQ-020 o_word SHALL be stable while o_word_valid=1.
REQ-021 Handshake (o_word_valid & i_word_ready) SHALL clear o_word_valid next cycle and return to ST_COLLECT; no pop in the handshake cycle.
REQ-022 i_flush=1 SHALL, next cycle, clear byte_cnt, timeout counter, o_word_valid and enter ST_COLLECT; flush overrides handshake, pop and timeout in the same cycle.
REQ-023 Bytes beyond the current word SHALL remain in the FIFO while in ST_OUTPUT (backpressure via FIFO).

Reset
REQ-024 On i_rst: state ST_COLLECT, byte_cnt 0, o_word 0, o_word_valid 0, o_timeout 0, timeout counter 0; o_rd 0 while reset asserted.
REQ-025 Reset asserted mid-word or with a word pending SHALL discard it; no spurious pops after release.

Configuration
REQ-026 Macro UART_WORD_TIMEOUT_EN, defined: in ST_COLLECT with byte_cnt>0 and no pop, counter increments; pop clears it; counter==i_timeout_cmp (nonzero) SHALL clear byte_cnt and counter and pulse o_timeout one cycle.
REQ-027 Timeout and a pop in the same cycle: the pop wins, counter clears, no timeout.
REQ-028 Macro undefined: no counter logic, i_timeout_cmp ignored, o_timeout tied 0; ports retained.

Structure
REQ-029 Shared package uart_word_pkg SHALL hold FSM state encodings and default NB_DATA/NB_WORD/NB_TIMEOUT constants.
REQ-030 Timeout counter SHALL be sub-module uart_byte_timer (inputs count-enable, clear, compare; output expire pulse), instantiated only under UART_WORD_TIMEOUT_EN.

Verification
REQ-031 FIFO bytes 0x11,0x22,0x33,0x44, ready=1 -> four consecutive o_rd pulses; o_word=0x44332211, o_word_valid high exactly 1 cycle, asserted 1 cycle after 4th pop.
REQ-032 8 bytes 0x01..0x08 queued, ready=0 for 20 cycles -> o_rd stops after 4 pops, o_word=0x04030201 stable; ready=1 -> next word 0x08070605.
REQ-033 Bytes 0xAA,0xBB then i_flush pulse, then 0x01..0x04 -> o_word=0x04030201; 0xAA/0xBB never appear.
REQ-034 (TIMEOUT_EN) i_timeout_cmp=10, byte 0x55 then 10 empty cycles -> o_timeout pulse, byte_cnt 0; subsequent 0x01..0x04 -> 0x04030201.
REQ-035 i_rst asserted asynchronously after 3 bytes, released, then 0x01..0x04 -> all outputs 0 during reset; o_word=0x04030201.
REQ-036 Flush and handshake in same cycle with 4 bytes queued -> o_word_valid 0 next cycle, next word assembled from queued bytes.
